// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: serialises an 8-bit request vector into one 3-bit index
// beat per set bit, with valid/ready handshakes on both sides.
// MSB_FIRST selects emission order: 0 = lowest set bit first, 1 = highest first.
// Optional build macro ENCODER_ZERO_FLAG_EN: an all-zero request produces a
// single beat flagged with output_zero; without it, all-zero requests are dropped.
module encoder_8to3_seq #(
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic       input_clock,
    input  logic       input_reset,
    input  logic       input_req_valid,
    input  logic [7:0] input_req_bus,
    output logic       output_req_ready,
    output logic [2:0] output_code,
    output logic       output_valid,
    input  logic       input_out_ready,
    output logic       output_last,
    output logic       output_zero
);

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [REQ_W-1:0]    r_pending;
    logic [CODE_W-1:0]   r_code;
    logic                r_last;
    logic                r_valid;
    logic                r_ready;
    logic                r_zero;

    logic                w_accept;
    logic                w_beat;
    logic [CODE_W-1:0]   w_req_pick;
    logic                w_req_single;
    logic [REQ_W-1:0]    w_pend_clr;
    logic [CODE_W-1:0]   w_pend_pick;
    logic                w_pend_single;

    // Index of the next bit to emit: highest or lowest set bit depending on MSB_FIRST.
    function automatic logic [CODE_W-1:0] f_pick(input logic [REQ_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < int'(REQ_W); i++) begin
                if (v[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int i = int'(REQ_W) - 1; i >= 0; i--) begin
                if (v[i]) idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic f_single(input logic [REQ_W-1:0] v);
        return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
    endfunction

    assign w_accept      = input_req_valid & r_ready;
    assign w_beat        = r_valid & input_out_ready;
    assign w_req_pick    = f_pick(input_req_bus);
    assign w_req_single  = f_single(input_req_bus);
    assign w_pend_clr    = r_pending & ~(REQ_W'(1) << r_code);
    assign w_pend_pick   = f_pick(w_pend_clr);
    assign w_pend_single = f_single(w_pend_clr);

    // Control FSM with registered outputs; the next beat is precomputed so outputs never see inputs combinationally.
    always_ff @(posedge input_clock) begin
        if (input_reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_code    <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_zero    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (input_req_bus != '0) begin
                            r_state   <= ST_EMIT;
                            r_pending <= input_req_bus;
                            r_code    <= w_req_pick;
                            r_last    <= w_req_single;
                            r_valid   <= 1'b1;
                            r_zero    <= 1'b0;
                            r_ready   <= 1'b0;
                        end
`ifdef ENCODER_ZERO_FLAG_EN
                        else begin
                            r_state   <= ST_EMIT;
                            r_pending <= '0;
                            r_code    <= '0;
                            r_last    <= 1'b1;
                            r_valid   <= 1'b1;
                            r_zero    <= 1'b1;
                            r_ready   <= 1'b0;
                        end
`endif
                    end
                end
                ST_EMIT: begin
                    if (w_beat) begin
                        if (r_last) begin
                            r_state   <= ST_IDLE;
                            r_pending <= '0;
                            r_code    <= '0;
                            r_last    <= 1'b0;
                            r_valid   <= 1'b0;
                            r_zero    <= 1'b0;
                            r_ready   <= 1'b1;
                        end else begin
                            r_pending <= w_pend_clr;
                            r_code    <= w_pend_pick;
                            r_last    <= w_pend_single;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_req_ready = r_ready;
    assign output_valid     = r_valid;
    assign output_code      = r_code;
    assign output_last      = r_last;
    assign output_zero      = r_zero;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Self-checking bench for encoder_8to3_seq: two instances (LSB-first and
// MSB-first) share stimulus; a reference model fills per-instance scoreboards.
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_bus;
    logic       out_ready;

    logic       ready0, valid0, last0, zero0;
    logic [2:0] code0;
    logic       ready1, valid1, last1, zero1;
    logic [2:0] code1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic       zero;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    encoder_8to3_seq #(.MSB_FIRST(0)) dut_lsb (
        .input_clock      (clk),
        .input_reset      (rst),
        .input_req_valid  (req_valid),
        .input_req_bus    (req_bus),
        .output_req_ready (ready0),
        .output_code      (code0),
        .output_valid     (valid0),
        .input_out_ready  (out_ready),
        .output_last      (last0),
        .output_zero      (zero0)
    );

    encoder_8to3_seq #(.MSB_FIRST(1)) dut_msb (
        .input_clock      (clk),
        .input_reset      (rst),
        .input_req_valid  (req_valid),
        .input_req_bus    (req_bus),
        .output_req_ready (ready1),
        .output_code      (code1),
        .output_valid     (valid1),
        .input_out_ready  (out_ready),
        .output_last      (last1),
        .output_zero      (zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected beat sequence for one accepted request.
    task automatic push_req(input logic [7:0] v);
        int cnt;
        int n;
        cnt = $countones(v);
        if (v == 8'h00) begin
`ifdef ENCODER_ZERO_FLAG_EN
            q0.push_back('{code: 3'd0, last: 1'b1, zero: 1'b1});
            q1.push_back('{code: 3'd0, last: 1'b1, zero: 1'b1});
`endif
        end else begin
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    n++;
                    q0.push_back('{code: 3'(i), last: (n == cnt), zero: 1'b0});
                end
            end
            n = 0;
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    n++;
                    q1.push_back('{code: 3'(i), last: (n == cnt), zero: 1'b0});
                end
            end
        end
    endtask

    // Compare the current beat of both instances with the scoreboard front; pop if consumed.
    task automatic check_beat(input string tag, input bit consume);
        beat_t e0;
        beat_t e1;
        chk({tag, "_valid0"}, 32'(valid0), 32'd1);
        chk({tag, "_valid1"}, 32'(valid1), 32'd1);
        chk({tag, "_ready0"}, 32'(ready0), 32'd0);
        chk({tag, "_sb0_nonempty"}, 32'(q0.size() != 0), 32'd1);
        chk({tag, "_sb1_nonempty"}, 32'(q1.size() != 0), 32'd1);
        if (q0.size() != 0 && q1.size() != 0) begin
            e0 = q0[0];
            e1 = q1[0];
            if (consume) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            chk({tag, "_code0"}, 32'(code0), 32'(e0.code));
            chk({tag, "_last0"}, 32'(last0), 32'(e0.last));
            chk({tag, "_zero0"}, 32'(zero0), 32'(e0.zero));
            chk({tag, "_code1"}, 32'(code1), 32'(e1.code));
            chk({tag, "_last1"}, 32'(last1), 32'(e1.last));
            chk({tag, "_zero1"}, 32'(zero1), 32'(e1.zero));
        end
    endtask

    // Idle: ready high, no beat, all beat fields zero.
    task automatic check_idle(input string tag);
        chk({tag, "_valid0"}, 32'(valid0), 32'd0);
        chk({tag, "_valid1"}, 32'(valid1), 32'd0);
        chk({tag, "_ready0"}, 32'(ready0), 32'd1);
        chk({tag, "_ready1"}, 32'(ready1), 32'd1);
        chk({tag, "_code0"}, 32'(code0), 32'd0);
        chk({tag, "_last0"}, 32'(last0), 32'd0);
        chk({tag, "_zero0"}, 32'(zero0), 32'd0);
        chk({tag, "_code1"}, 32'(code1), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_bus   = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;

        // Single-bit request: one beat in the cycle after accept, ready back next cycle.
        req_valid = 1'b1;
        req_bus   = 8'b0000_0001;
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
        check_beat("single", 1'b1);
        tick();
        check_idle("single_done");

        // Multi-bit request at full throughput.
        req_valid = 1'b1;
        req_bus   = 8'b1010_0110;
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat("a6_beat", 1'b1);
            tick();
        end
        check_idle("a6_done");

        // Backpressure on the first beat; a request during EMIT must be ignored.
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_bus   = 8'b1000_0001;
        push_req(req_bus);
        tick();
        req_bus = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check_beat("stall_hold", 1'b0);
            tick();
        end
        out_ready = 1'b1;
        check_beat("stall_b0", 1'b1);
        tick();
        check_beat("stall_b1", 1'b1);
        tick();
        req_valid = 1'b0;
        check_idle("stall_done");
        tick();
        check_idle("stall_no_accept");

        // Reset mid-EMIT while a handshake is also occurring.
        req_valid = 1'b1;
        req_bus   = 8'b1111_1111;
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("ff_beat", 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        check_idle("mid_reset");
        tick();
        check_idle("mid_reset_quiet");
        req_valid = 1'b1;
        req_bus   = 8'b0001_0000;
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
        check_beat("after_reset", 1'b1);
        tick();
        check_idle("after_reset_done");

        // Reset wins over a simultaneous accept.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_bus   = 8'b0000_0100;
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        check_idle("reset_vs_accept");
        tick();
        check_idle("reset_vs_accept_quiet");

        // All-zero request.
        req_valid = 1'b1;
        req_bus   = 8'h00;
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
`ifdef ENCODER_ZERO_FLAG_EN
        check_beat("zero_req", 1'b1);
        tick();
        check_idle("zero_done");
`else
        check_idle("zero_dropped");
        tick();
        check_idle("zero_dropped_quiet");
`endif

        // Back-to-back requests with valid held high.
        req_valid = 1'b1;
        req_bus   = 8'b0000_0011;
        push_req(req_bus);
        tick();
        req_bus = 8'b0100_0000;
        check_beat("b2b_first0", 1'b1);
        tick();
        check_beat("b2b_first1", 1'b1);
        tick();
        check_idle("b2b_gap");
        push_req(req_bus);
        tick();
        req_valid = 1'b0;
        check_beat("b2b_second", 1'b1);
        tick();
        check_idle("b2b_done");

        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
